// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memory path.
// Holds the 4-bit load/store opcode encodings, which are shared with the
// decoder and the data memory. Also holds the LSU FSM state type and small
// opcode classification helpers.
package mips_pkg;

    localparam logic [3:0] LSOP_SW = 4'd0;
    localparam logic [3:0] LSOP_SH = 4'd1;
    localparam logic [3:0] LSOP_SB = 4'd2;
    localparam logic [3:0] LSOP_LW = 4'd3;
    localparam logic [3:0] LSOP_LH = 4'd4;
    localparam logic [3:0] LSOP_LB = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_t;

    // Codes 6..15 are not memory operations.
    function automatic logic lsop_is_mem(input logic [3:0] op);
        return (op <= LSOP_LB);
    endfunction

    function automatic logic lsop_is_load(input logic [3:0] op);
        return (op == LSOP_LW) || (op == LSOP_LH) || (op == LSOP_LB);
    endfunction

    function automatic logic lsop_is_store(input logic [3:0] op);
        return (op == LSOP_SW) || (op == LSOP_SH) || (op == LSOP_SB);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data memory request/acknowledge bus between the LSU and the data memory.
//   mem_req   : request valid, held until mem_ack
//   mem_we    : 1 = write
//   mem_addr  : word-aligned byte address
//   mem_be    : byte enables, bit i covers bits 8i+7:8i
//   mem_wdata : lane-steered store data
//   mem_ack   : memory completes the request this cycle
//   mem_rdata : read word, valid with mem_ack
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU.
//   lsop       : load/store opcode
//   addr_lo    : byte offset within the word
//   wdata      : right-justified store data
//   mem_rdata  : raw read word from memory
//   be         : byte enables for the access
//   wdata_lane : store data replicated onto the addressed lanes
//   misalign   : access not naturally aligned
//   rdata_ext  : extracted and sign-extended load result
module lsu_align
    import mips_pkg::*;
(
    input  logic [3:0]  lsop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    logic [7:0]  lane_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_byte[gi] = mem_rdata[8*gi +: 8];
    end

    assign byte_sel = lane_byte[addr_lo];
    assign half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        misalign   = 1'b0;
        rdata_ext  = 32'h0;
        case (lsop)
            LSOP_SW: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                misalign   = (addr_lo != 2'b00);
            end
            LSOP_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {wdata[15:0], wdata[15:0]};
                misalign   = addr_lo[0];
            end
            LSOP_SB: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            LSOP_LW: begin
                be         = 4'b1111;
                rdata_ext  = mem_rdata;
                misalign   = (addr_lo != 2'b00);
            end
            LSOP_LH: begin
                be         = 4'b1111;
                rdata_ext  = {{16{half_sel[15]}}, half_sel};
                misalign   = addr_lo[0];
            end
            LSOP_LB: begin
                be         = 4'b1111;
                rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store initiator.
// Accepts one decoded load/store, runs a req/ack transaction on the data
// memory bus, and stalls the pipeline until it completes. Detects misaligned
// accesses and bus timeouts.
//   clk, reset      : clock, synchronous active-high reset
//   op_valid, lsop  : MEM stage memory op and its opcode
//   addr, wdata, pc : byte address, store data, instruction PC
//   stall           : freeze IF..MEM this cycle
//   rdata/_valid    : extended load result, one-cycle valid pulse
//   misalign        : alignment fault pulse
//   bus_err         : timeout fault pulse
//   err_pc          : PC of the last faulting instruction
//   mem             : data memory bus (master side)
module lsu_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  lsop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        bus_err,
    output logic [31:0] err_pc,
    lsu_ctrl_if.master  mem
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    lsu_state_t  state_reg, state_next;
    logic [3:0]  lsop_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] pc_reg;
    logic [9:0]  cnt_reg;
    logic [31:0] rdata_reg;
    logic [31:0] err_pc_reg;
    logic        cause_bus_reg;

    logic accept;
    logic fault_misalign;
    logic timeout_hit;
    logic in_req;

    // The alignment check looks at the live MEM-stage op while idle; in every
    // other state the lane logic works on the latched op.
    logic [3:0]  al_lsop;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_rdata_ext;

    assign al_lsop    = (state_reg == ST_IDLE) ? lsop       : lsop_reg;
    assign al_addr_lo = (state_reg == ST_IDLE) ? addr[1:0]  : addr_reg[1:0];

    lsu_align u_align (
        .lsop       (al_lsop),
        .addr_lo    (al_addr_lo),
        .wdata      (wdata_reg),
        .mem_rdata  (mem.mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .misalign   (al_misalign),
        .rdata_ext  (al_rdata_ext)
    );

    always_comb begin
        state_next     = state_reg;
        stall          = 1'b0;
        accept         = 1'b0;
        fault_misalign = 1'b0;
        timeout_hit    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (op_valid && lsop_is_mem(lsop)) begin
                    stall = 1'b1;
                    if (al_misalign) begin
                        state_next     = ST_ERR;
                        fault_misalign = 1'b1;
                    end else begin
                        state_next = ST_REQ;
                        accept     = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // An ack in the final counted cycle still completes normally.
                if (mem.mem_ack) begin
                    state_next = ST_DONE;
                end else if (cnt_reg == TO_LAST) begin
                    state_next  = ST_ERR;
                    timeout_hit = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            lsop_reg      <= 4'd0;
            addr_reg      <= 32'h0;
            wdata_reg     <= 32'h0;
            pc_reg        <= 32'h0;
            cnt_reg       <= 10'd0;
            rdata_reg     <= 32'h0;
            err_pc_reg    <= 32'h0;
            cause_bus_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                lsop_reg  <= lsop;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                pc_reg    <= pc;
                cnt_reg   <= 10'd0;
            end else if (state_reg == ST_REQ && !mem.mem_ack) begin
                cnt_reg <= cnt_reg + 10'd1;
            end
            if (state_reg == ST_REQ && mem.mem_ack && lsop_is_load(lsop_reg)) begin
                rdata_reg <= al_rdata_ext;
            end
            if (fault_misalign) begin
                err_pc_reg    <= pc;
                cause_bus_reg <= 1'b0;
            end else if (timeout_hit) begin
                err_pc_reg    <= pc_reg;
                cause_bus_reg <= 1'b1;
            end
        end
    end

    // Bus outputs are forced to zero outside REQ so nothing stale leaks out.
    assign in_req        = (state_reg == ST_REQ);
    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req && lsop_is_store(lsop_reg);
    assign mem.mem_addr  = in_req ? {addr_reg[31:2], 2'b00} : 32'h0;
    assign mem.mem_be    = in_req ? al_be : 4'b0000;
    assign mem.mem_wdata = in_req ? al_wdata : 32'h0;

    assign rdata       = rdata_reg;
    assign rdata_valid = (state_reg == ST_DONE) && lsop_is_load(lsop_reg);
    assign misalign    = (state_reg == ST_ERR) && !cause_bus_reg;
    assign bus_err     = (state_reg == ST_ERR) && cause_bus_reg;
    assign err_pc      = err_pc_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a hand-driven data memory.
module tb_lsu_ctrl;
    import mips_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [3:0]  lsop;
    logic [31:0] addr, wdata, pc;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid, misalign, bus_err;
    logic [31:0] err_pc;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .lsop        (lsop),
        .addr        (addr),
        .wdata       (wdata),
        .pc          (pc),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .err_pc      (err_pc),
        .mem         (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-operation observations gathered by run_op.
    int          r_stall, r_req, r_valid, r_mis, r_bus;
    logic [31:0] r_rdata, r_addr, r_wdata;
    logic [3:0]  r_be;
    logic        r_we, r_stable;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op and act as memory; waits<0 means never acknowledge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] p, input int waits, input logic [31:0] rd);
        logic retired;
        retired  = 1'b0;
        r_stall  = 0; r_req = 0; r_valid = 0; r_mis = 0; r_bus = 0;
        r_rdata  = 32'h0; r_addr = 32'h0; r_wdata = 32'h0; r_be = 4'h0;
        r_we     = 1'b0; r_stable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) begin
                op_valid = 1'b1; lsop = op; addr = a; wdata = wd; pc = p;
            end else if (retired) begin
                op_valid = 1'b0;
            end
            #1;
            if (stall) r_stall++;
            if (bus.mem_req) begin
                r_req++;
                if (r_req == 1) begin
                    r_addr = bus.mem_addr; r_be = bus.mem_be;
                    r_wdata = bus.mem_wdata; r_we = bus.mem_we;
                end else if (bus.mem_addr !== r_addr || bus.mem_be !== r_be ||
                             bus.mem_wdata !== r_wdata || bus.mem_we !== r_we) begin
                    r_stable = 1'b0;
                end
            end
            bus.mem_ack   = bus.mem_req && (waits >= 0) && (r_req == waits + 1);
            bus.mem_rdata = rd;
            if (rdata_valid) begin r_valid++; r_rdata = rdata; end
            if (misalign) r_mis++;
            if (bus_err)  r_bus++;
            if (k > 0 && !stall) retired = 1'b1;
        end
        bus.mem_ack = 1'b0;
        op_valid    = 1'b0;
        $display("op lsop=%0d addr=%h: stall=%0d req=%0d valid=%0d rdata=%h mis=%0d bus=%0d",
                 op, a, r_stall, r_req, r_valid, r_rdata, r_mis, r_bus);
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; lsop = 4'd15; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mem_req",   {31'h0, bus.mem_req}, 32'h0);
        chk("rst_mem_we",    {31'h0, bus.mem_we}, 32'h0);
        chk("rst_mem_addr",  bus.mem_addr, 32'h0);
        chk("rst_mem_be",    {28'h0, bus.mem_be}, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_rdata",     rdata, 32'h0);
        chk("rst_flags",     {29'h0, rdata_valid, misalign, bus_err}, 32'h0);
        chk("rst_err_pc",    err_pc, 32'h0);
        chk("rst_stall",     {31'h0, stall}, 32'h0);
        $display("reset state checked");

        // sw zero-wait
        run_op(LSOP_SW, 32'h10, 32'hDEADBEEF, 32'h1000, 0, 32'h0);
        chk("sw_addr",  r_addr, 32'h10);
        chk("sw_be",    {28'h0, r_be}, 32'hF);
        chk("sw_wdata", r_wdata, 32'hDEADBEEF);
        chk("sw_we",    {31'h0, r_we}, 32'h1);
        chk("sw_stall", r_stall, 2);
        chk("sw_req",   r_req, 1);
        chk("sw_valid", r_valid, 0);

        // sb lane 3, then lb from lane 3
        run_op(LSOP_SB, 32'h13, 32'h000000A5, 32'h1004, 0, 32'h0);
        chk("sb_be",    {28'h0, r_be}, 32'h8);
        chk("sb_wdata", r_wdata, 32'hA5A5A5A5);
        chk("sb_addr",  r_addr, 32'h10);
        run_op(LSOP_LB, 32'h13, 32'h0, 32'h1008, 0, 32'hA5000000);
        chk("lb_rdata", r_rdata, 32'hFFFFFFA5);
        chk("lb_valid", r_valid, 1);
        chk("lb_we",    {31'h0, r_we}, 32'h0);
        chk("lb_be",    {28'h0, r_be}, 32'hF);

        // lh upper half, ack in the 4th REQ cycle (the timeout cycle)
        run_op(LSOP_LH, 32'h22, 32'h0, 32'h100C, 3, 32'h7FFF8000);
        chk("lh_rdata",  r_rdata, 32'h00007FFF);
        chk("lh_req",    r_req, 4);
        chk("lh_addr",   r_addr, 32'h20);
        chk("lh_stable", {31'h0, r_stable}, 32'h1);
        chk("lh_stall",  r_stall, 5);
        chk("lh_bus",    r_bus, 0);

        // lh lower half, negative
        run_op(LSOP_LH, 32'h20, 32'h0, 32'h1010, 1, 32'h7FFF8000);
        chk("lh_lo_rdata", r_rdata, 32'hFFFF8000);

        // sh upper half, sb lane 1, lb lane 1
        run_op(LSOP_SH, 32'h02, 32'h1234ABCD, 32'h1014, 0, 32'h0);
        chk("sh_be",    {28'h0, r_be}, 32'hC);
        chk("sh_wdata", r_wdata, 32'hABCDABCD);
        run_op(LSOP_SB, 32'h11, 32'h0000003C, 32'h1018, 2, 32'h0);
        chk("sb1_be",    {28'h0, r_be}, 32'h2);
        chk("sb1_wdata", r_wdata, 32'h3C3C3C3C);
        run_op(LSOP_LB, 32'h11, 32'h0, 32'h101C, 0, 32'h00008000);
        chk("lb1_rdata", r_rdata, 32'hFFFFFF80);

        // misaligned lw
        run_op(LSOP_LW, 32'h06, 32'h0, 32'h3008, 0, 32'h0);
        chk("mis_req",    r_req, 0);
        chk("mis_pulse",  r_mis, 1);
        chk("mis_err_pc", err_pc, 32'h3008);
        chk("mis_stall",  r_stall, 1);
        chk("mis_valid",  r_valid, 0);

        // misaligned sh
        run_op(LSOP_SH, 32'h21, 32'h0, 32'h300C, 0, 32'h0);
        chk("mis_sh_pulse", r_mis, 1);
        chk("mis_sh_req",   r_req, 0);
        chk("mis_sh_pc",    err_pc, 32'h300C);

        // non-memory opcode
        run_op(4'd7, 32'h40, 32'h0, 32'h3010, 0, 32'h0);
        chk("nop_stall", r_stall, 0);
        chk("nop_req",   r_req, 0);

        // timeout
        run_op(LSOP_LW, 32'h50, 32'h0, 32'h4000, -1, 32'h12345678);
        chk("to_req",    r_req, TIMEOUT);
        chk("to_bus",    r_bus, 1);
        chk("to_mis",    r_mis, 0);
        chk("to_err_pc", err_pc, 32'h4000);
        chk("to_valid",  r_valid, 0);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        chk("late_ack_valid", {31'h0, rdata_valid}, 32'h0);
        chk("late_ack_req",   {31'h0, bus.mem_req}, 32'h0);
        $display("late ack: rdata_valid=%0b mem_req=%0b", rdata_valid, bus.mem_req);

        // err_pc held over a successful op
        run_op(LSOP_SW, 32'h60, 32'h0BADF00D, 32'h5000, 0, 32'h0);
        chk("held_err_pc", err_pc, 32'h4000);

        // reset on the 2nd REQ cycle
        @(negedge clk);
        op_valid = 1'b1; lsop = LSOP_LW; addr = 32'h40; pc = 32'h6000;
        @(negedge clk);
        #1;
        chk("rst_req1", {31'h0, bus.mem_req}, 32'h1);
        @(negedge clk);
        reset = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rstmid_req",   {31'h0, bus.mem_req}, 32'h0);
        chk("rstmid_addr",  bus.mem_addr, 32'h0);
        chk("rstmid_be",    {28'h0, bus.mem_be}, 32'h0);
        chk("rstmid_flags", {28'h0, stall, rdata_valid, misalign, bus_err}, 32'h0);
        chk("rstmid_errpc", err_pc, 32'h0);
        $display("reset mid-REQ: mem_req=%0b stall=%0b", bus.mem_req, stall);
        run_op(LSOP_SW, 32'h70, 32'hCAFEBABE, 32'h7000, 0, 32'h0);
        chk("post_rst_addr",  r_addr, 32'h70);
        chk("post_rst_wdata", r_wdata, 32'hCAFEBABE);
        chk("post_rst_stall", r_stall, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator for the MEM stage of the pipelined MIPS core. Takes one decoded load/store per instruction and runs a req/ack transaction to a word-organised, byte-enabled data memory. Stalls the pipeline until the transaction completes. Owns store lane steering and byte enables, load extraction and sign extension, alignment checks, and a bus timeout.

## Interface
Parameters:
- TIMEOUT, 255: max cycles in REQ without mem_ack before bus error; legal range 2..1023.

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op_valid  in  1  MEM stage holds a load/store this cycle
- lsop  in  4  sw=0, sh=1, sb=2, lw=3, lh=4, lb=5; 6..15 not memory ops
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- pc  in  32  PC of the MEM-stage instruction
- stall  out  1  freeze IF..MEM this cycle
- rdata  out  32  extended load result
- rdata_valid  out  1  rdata valid; one-cycle pulse
- misalign  out  1  alignment fault; one-cycle pulse
- bus_err  out  1  timeout fault; one-cycle pulse
- err_pc  out  32  pc of faulting instruction, held until next fault
- mem_req  out  1  request to memory
- mem_we  out  1  1=write
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i)
- mem_wdata  out  32  lane-steered store data
- mem_ack  in  1  memory completes the request this cycle
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE, op_valid=1, lsop<=5, aligned: latch lsop, addr, wdata and pc; go to REQ.
- IDLE, op_valid=1, lsop<=5, misaligned: go to ERR with misalign cause. Misaligned means lw/sw with addr[1:0]!=0, or lh/sh with addr[0]!=0. No memory request is issued.
- IDLE, op_valid=0 or lsop>=6: stay in IDLE; stall=0.
- REQ: mem_req=1; all mem_* outputs are driven from the latched values and are stable. On mem_ack=1, go to DONE. On timeout, go to ERR with bus_err cause.
- DONE: one cycle. For loads, rdata_valid=1 and rdata carries the result. Always returns to IDLE; op_valid is ignored in DONE because it is the same instruction.
- ERR: one cycle. The cause pulse is high and err_pc is loaded. Returns to IDLE.
- Stores:
  - sw: be=1111, data=wdata.
  - sh: data={wdata[15:0],wdata[15:0]}; be=1100 if addr[1], else 0011.
  - sb: data is wdata[7:0] replicated 4x; be=0001<<addr[1:0].
- Loads: mem_we=0, be=1111. rdata is sign-extended:
  - lw: the word.
  - lh: halfword addr[1].
  - lb: byte addr[1:0].
  - The result is registered from mem_rdata on the ack edge.
- Timeout counter: cleared on REQ entry and incremented each REQ cycle without ack. A count of TIMEOUT-1 with no ack means timeout. Ack in the timeout cycle wins.
- mem_ack outside REQ is ignored, including a late ack after a timeout.

## Timing
- Reset values: FSM=IDLE; mem_req, mem_we, mem_be, mem_wdata, mem_addr, rdata, rdata_valid, misalign, bus_err, err_pc all 0.
- stall is combinational: 1 in IDLE when op_valid=1 and lsop<=5; 1 in REQ; 0 in DONE, ERR and all other cases.
- Latency: op accepted at edge N; mem_req high from N to the ack edge. Zero-wait memory (ack in first REQ cycle) gives IDLE→REQ→DONE: 2 stall cycles, rdata_valid on cycle 3.
- Back-to-back ops: DONE→IDLE; the next instruction is sampled in IDLE, so each op costs 3+wait cycles.
- Reset in any state: back to IDLE at that edge; mem_req low next cycle; any in-flight transaction is abandoned.

## Structure
- Shared package mips_pkg holds the LSOP_* 4-bit constants (shared with the decoder and data memory) and the FSM state typedef.
- Sub-module lsu_align is purely combinational: lane steering, be generation, alignment check and load extraction/extension. lsu_ctrl holds the FSM, latches, timeout counter and error registers.

## Test plan
- Zero-wait memory: sw addr=0x10, wdata=0xDEADBEEF → mem_addr=0x10, be=1111, mem_wdata=0xDEADBEEF, mem_we=1; exactly 2 stall cycles.
- sb addr=0x13, wdata=0x000000A5 → be=1000, mem_wdata=0xA5A5A5A5. Then lb addr=0x13 with mem_rdata=0xA5000000 → rdata=0xFFFFFFA5 with rdata_valid pulse.
- lh addr=0x22, mem_rdata=0x7FFF8000, ack after 3 wait cycles → rdata=0x00007FFF; mem_req high 4 cycles with stable addr=0x20.
- lw addr=0x06, pc=0x3008 → no mem_req; misalign pulse; err_pc=0x3008; stall 1 cycle.
- TIMEOUT=4, no ack → mem_req high 4 cycles, then bus_err pulse. A late mem_ack in IDLE produces no rdata_valid.
- reset asserted on the 2nd REQ cycle → mem_req=0 next cycle, FSM in IDLE, all outputs 0. A following sw completes normally.
